// File: rtl/wvb_readout_ctrl.sv
// rtl/wvb_readout_ctrl.sv - single-channel waveform buffer readout sequencer
// Pops one header, streams its samples from the waveform RAM with valid/ready, then pulses rddone.
module wvb_readout_ctrl #(
    parameter int P_ADR_WIDTH  = 12,
    parameter int P_DATA_WIDTH = 22,
    parameter int P_HDR_WIDTH  = 80
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [P_HDR_WIDTH-1:0]  hdr_data,
    input  logic                    hdr_empty,
    output logic                    hdr_rdreq,
    output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
    output logic                    wvb_rd_en,
    input  logic [P_DATA_WIDTH-1:0] wvb_data,
    output logic                    wvb_rddone,
    output logic [P_HDR_WIDTH-1:0]  hdr_out,
    output logic [P_DATA_WIDTH-1:0] dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    dout_first,
    output logic                    dout_last,
    output logic                    busy
);
    localparam int CW = P_ADR_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic                    run_q;
    logic [P_HDR_WIDTH-1:0]  hdr_q, hdr_d;
    logic [P_ADR_WIDTH-1:0]  addr_q, addr_d;
    logic [CW-1:0]           len_q, len_d;
    logic [CW-1:0]           rd_left_q, rd_left_d;
    logic [CW-1:0]           out_idx_q, out_idx_d;
    logic                    infl_q, infl_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [P_DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;

    logic [P_ADR_WIDTH-1:0]  start_addr, stop_addr;
    logic [CW-1:0]           n_calc;
    logic [2:0]              held;
    logic                    pop, issue;

    assign start_addr  = hdr_q[20 +: P_ADR_WIDTH];
    assign stop_addr   = hdr_q[8 +: P_ADR_WIDTH];
    assign n_calc      = {1'b0, stop_addr - start_addr} + CW'(1);
    assign hdr_out     = hdr_q;
    assign wvb_rd_addr = addr_q;

    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        addr_d    = addr_q;
        len_d     = len_q;
        rd_left_d = rd_left_q;
        out_idx_d = out_idx_q;
        cnt_d     = cnt_q;
        buf0_d    = buf0_q;
        buf1_d    = buf1_q;
        hdr_rdreq  = 1'b0;
        wvb_rddone = 1'b0;
        issue      = 1'b0;

        // When the skid is empty the word arriving from the RAM is presented directly.
        dout_valid = (cnt_q != 2'd0) || infl_q;
        dout       = (cnt_q == 2'd0 && infl_q) ? wvb_data : buf0_q;
        pop        = dout_valid && dout_ready;
        dout_first = dout_valid && (out_idx_q == '0);
        dout_last  = dout_valid && (out_idx_q == len_q - CW'(1));
        held       = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};

        case (state_q)
            S_IDLE: begin
                if (run_q && en && !hdr_empty) begin
                    hdr_rdreq = 1'b1;
                    hdr_d     = hdr_data;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                len_d     = n_calc;
                rd_left_d = n_calc;
                addr_d    = start_addr;
                out_idx_d = '0;
                state_d   = S_STREAM;
            end
            S_STREAM: begin
                // A read lands next cycle, so it may only issue if one slot stays free even without a pop.
                issue = (rd_left_q != '0) && (held <= 3'd1);
                if (issue) begin
                    addr_d    = addr_q + P_ADR_WIDTH'(1);
                    rd_left_d = rd_left_q - CW'(1);
                end
                if (pop) begin
                    out_idx_d = out_idx_q + CW'(1);
                    if (dout_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                wvb_rddone = 1'b1;
                state_d    = S_IDLE;
            end
        endcase

        case (cnt_q)
            2'd0: begin
                if (infl_q && !pop) begin
                    buf0_d = wvb_data;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (pop && infl_q) begin
                    buf0_d = wvb_data;
                end else if (pop) begin
                    cnt_d = 2'd0;
                end else if (infl_q) begin
                    buf1_d = wvb_data;
                    cnt_d  = 2'd2;
                end
            end
            default: begin
                if (pop) begin
                    buf0_d = buf1_q;
                    cnt_d  = 2'd1;
                end
            end
        endcase

        infl_d    = issue;
        wvb_rd_en = issue;
        busy      = (state_q != S_IDLE) || hdr_rdreq;
    end

    // run_q keeps the header FIFO untouched until the first clock after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            run_q     <= 1'b0;
            hdr_q     <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            rd_left_q <= '0;
            out_idx_q <= '0;
            infl_q    <= 1'b0;
            cnt_q     <= 2'd0;
            buf0_q    <= '0;
            buf1_q    <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= 1'b1;
            hdr_q     <= hdr_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            rd_left_q <= rd_left_d;
            out_idx_q <= out_idx_d;
            infl_q    <= infl_d;
            cnt_q     <= cnt_d;
            buf0_q    <= buf0_d;
            buf1_q    <= buf1_d;
        end
    end
endmodule

// File: tb/tb_wvb_readout_ctrl.sv
// tb/tb_wvb_readout_ctrl.sv - randomized bench for wvb_readout_ctrl against an event-level model
module tb_wvb_readout_ctrl;
    localparam int AW = 12;
    localparam int DW = 22;
    localparam int HW = 80;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          dout_ready = 1'b0;
    logic [HW-1:0] hdr_data;
    logic          hdr_empty;
    logic          hdr_rdreq, wvb_rd_en, wvb_rddone, dout_valid, dout_first, dout_last, busy;
    logic [AW-1:0] wvb_rd_addr;
    logic [DW-1:0] wvb_data = '0;
    logic [DW-1:0] dout;
    logic [HW-1:0] hdr_out;

    wvb_readout_ctrl #(.P_ADR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_HDR_WIDTH(HW)) dut (
        .clk(clk), .rst(rst), .en(en),
        .hdr_data(hdr_data), .hdr_empty(hdr_empty), .hdr_rdreq(hdr_rdreq),
        .wvb_rd_addr(wvb_rd_addr), .wvb_rd_en(wvb_rd_en), .wvb_data(wvb_data),
        .wvb_rddone(wvb_rddone), .hdr_out(hdr_out),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_first(dout_first), .dout_last(dout_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // Header FIFO (first-word-fall-through) and waveform RAM models
    logic [HW-1:0] hdr_mem [0:63];
    logic [DW-1:0] mem [0:4095];
    logic [5:0]    wr_ptr = '0;
    logic [5:0]    rd_ptr = '0;
    assign hdr_empty = (rd_ptr == wr_ptr);
    assign hdr_data  = hdr_mem[rd_ptr];
    always @(posedge clk) if (hdr_rdreq) rd_ptr <= rd_ptr + 6'd1;
    always @(posedge clk) if (wvb_rd_en) wvb_data <= mem[wvb_rd_addr];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int since_rst = 0;
    int ready_pct = 100;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Event-level model state
    bit            in_event = 0, done_due = 0, prev_stall = 0, all_ready = 0;
    logic [HW-1:0] cur_hdr = '0;
    logic [DW+1:0] exp_q[$];
    logic [AW-1:0] rd_log[$];
    int            ev_n = 0, issued = 0, hs = 0, pop_cyc = 0;
    int            pop_cnt = 0, done_cnt = 0, last_lat = 0, last_hs = 0;
    logic [DW-1:0] prev_dout = '0;
    logic          prev_first = 1'b0, prev_last = 1'b0;

    always @(negedge clk) begin : cmp
        int s, n;
        logic [AW-1:0] a;
        bit exp_pop;
        if (rst) begin
            since_rst = 0;
            if (cyc > 0) begin
                chk("reset_ctrl", 128'({hdr_rdreq, wvb_rd_en, wvb_rddone, dout_valid, dout_first, dout_last, busy}), 128'(0));
                chk("reset_data", 128'({hdr_out, dout, wvb_rd_addr}), 128'(0));
            end
            in_event = 0;
            done_due = 0;
            prev_stall = 0;
            exp_q.delete();
        end else begin
            since_rst++;
            exp_pop = !in_event && en && !hdr_empty;
            if (since_rst > 2) chk("hdr_rdreq", 128'(hdr_rdreq), 128'(exp_pop));
            else if (hdr_rdreq) chk("hdr_rdreq_early", 128'(exp_pop), 128'(1));
            chk("busy", 128'(busy), 128'(in_event || hdr_rdreq));
            if (hdr_rdreq && !in_event) begin
                cur_hdr = hdr_data;
                s = int'(hdr_data[31:20]);
                n = ((int'(hdr_data[19:8]) - s) & 4095) + 1;
                exp_q.delete();
                for (int i = 0; i < n; i++) begin
                    a = AW'(s + i);
                    exp_q.push_back({i == 0, i == n - 1, mem[a]});
                end
                ev_n = n;
                issued = 0;
                hs = 0;
                pop_cyc = cyc;
                all_ready = (ready_pct == 100);
                in_event = 1;
                done_due = 0;
                prev_stall = 0;
                pop_cnt++;
                chk("pop_quiet", 128'({wvb_rd_en, dout_valid, wvb_rddone}), 128'(0));
            end else if (in_event) begin
                chk("hdr_out", 128'(hdr_out), 128'(cur_hdr));
                chk("rddone", 128'(wvb_rddone), 128'(done_due));
                done_due = 0;
                if (wvb_rd_en) begin
                    issued++;
                    rd_log.push_back(wvb_rd_addr);
                end
                if (prev_stall)
                    chk("stall_hold", 128'({dout_valid, dout_first, dout_last, dout}),
                        128'({1'b1, prev_first, prev_last, prev_dout}));
                if (dout_valid) begin
                    if (exp_q.size() == 0) chk("extra_sample", 128'(1), 128'(0));
                    else begin
                        chk("sample", 128'({dout_first, dout_last, dout}), 128'(exp_q[0]));
                        if (dout_ready) begin
                            void'(exp_q.pop_front());
                            hs++;
                            if (exp_q.size() == 0) done_due = 1;
                        end
                    end
                end
                chk("skid_bound", 128'(issued - hs <= 2), 128'(1));
                prev_stall = dout_valid && !dout_ready;
                prev_dout = dout;
                prev_first = dout_first;
                prev_last = dout_last;
                if (wvb_rddone) begin
                    chk("n_reads", 128'(issued), 128'(ev_n));
                    last_lat = cyc - pop_cyc;
                    last_hs = hs;
                    done_cnt++;
                    if (all_ready) chk("latency", 128'(last_lat), 128'(ev_n + 3));
                    in_event = 0;
                end
            end else begin
                chk("idle_quiet", 128'({wvb_rd_en, dout_valid, wvb_rddone}), 128'(0));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            dout_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_hdr(input logic [AW-1:0] s, input logic [AW-1:0] e);
        hdr_mem[wr_ptr] = {32'($urandom()), 16'($urandom()), s, e, 8'($urandom())};
        wr_ptr = wr_ptr + 6'd1;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            tick(1);
            k++;
        end
        chk("done_reached", 128'(done_cnt >= target), 128'(1));
    endtask

    logic [AW-1:0] exp_a[4];
    int base_pop, base_done, len, k;
    logic [AW-1:0] st;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = DW'($urandom());
        for (int i = 0; i < 64; i++) hdr_mem[i] = '0;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        en = 1'b1;
        tick(2);

        rd_log.delete();
        push_hdr(12'h010, 12'h013);
        wait_done(1, 100);
        exp_a = '{12'h010, 12'h011, 12'h012, 12'h013};
        chk("t1_nreads", 128'(rd_log.size()), 128'(4));
        if (rd_log.size() == 4)
            for (int i = 0; i < 4; i++) chk("t1_addr", 128'(rd_log[i]), 128'(exp_a[i]));
        chk("t1_samples", 128'(last_hs), 128'(4));
        chk("t1_latency", 128'(last_lat), 128'(7));

        rd_log.delete();
        push_hdr(12'hFFE, 12'h001);
        wait_done(2, 100);
        exp_a = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        chk("t2_nreads", 128'(rd_log.size()), 128'(4));
        if (rd_log.size() == 4)
            for (int i = 0; i < 4; i++) chk("t2_addr", 128'(rd_log[i]), 128'(exp_a[i]));
        chk("t2_samples", 128'(last_hs), 128'(4));

        rd_log.delete();
        push_hdr(12'h100, 12'h100);
        wait_done(3, 100);
        chk("t3_nreads", 128'(rd_log.size()), 128'(1));
        chk("t3_samples", 128'(last_hs), 128'(1));
        chk("t3_latency", 128'(last_lat), 128'(4));

        rd_log.delete();
        ready_pct = 30;
        push_hdr(12'h000, 12'hFFF);
        wait_done(4, 20000);
        chk("t4_samples", 128'(last_hs), 128'(4096));
        chk("t4_nreads", 128'(rd_log.size()), 128'(4096));

        ready_pct = 60;
        base_pop = pop_cnt;
        base_done = done_cnt;
        push_hdr(12'h400, 12'h413);
        push_hdr(12'h500, 12'h513);
        push_hdr(12'h600, 12'h613);
        k = 0;
        while (pop_cnt < base_pop + 2 && k < 500) begin
            tick(1);
            k++;
        end
        en = 1'b0;
        wait_done(base_done + 2, 500);
        tick(20);
        chk("t5_held_pops", 128'(pop_cnt), 128'(base_pop + 2));
        chk("t5_held_done", 128'(done_cnt), 128'(base_done + 2));
        en = 1'b1;
        wait_done(base_done + 3, 500);
        chk("t5_pops", 128'(pop_cnt), 128'(base_pop + 3));

        ready_pct = 100;
        base_pop = pop_cnt;
        base_done = done_cnt;
        push_hdr(12'h200, 12'h263);
        push_hdr(12'h300, 12'h30F);
        k = 0;
        while (!(pop_cnt == base_pop + 1 && hs >= 40) && k < 500) begin
            tick(1);
            k++;
        end
        chk("t6_mid_stream", 128'(in_event && hs >= 40), 128'(1));
        rst = 1'b1;
        tick(3);
        chk("t6_no_done", 128'(done_cnt), 128'(base_done));
        rst = 1'b0;
        wait_done(base_done + 1, 300);
        chk("t6_next_samples", 128'(last_hs), 128'(16));
        chk("t6_pops", 128'(pop_cnt), 128'(base_pop + 2));

        for (int e = 0; e < 12; e++) begin
            ready_pct = (e % 3 == 0) ? 100 : $urandom_range(20, 90);
            base_done = done_cnt;
            len = $urandom_range(1, 150);
            st = AW'($urandom());
            push_hdr(st, AW'(int'(st) + len - 1));
            len = $urandom_range(1, 150);
            st = AW'($urandom());
            push_hdr(st, AW'(int'(st) + len - 1));
            wait_done(base_done + 2, 2000);
        end

        tick(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wvb_readout_ctrl.md
# wvb_readout_ctrl

Sequences readout of one mDOM waveform buffer channel. It pops one event header from the header FIFO and reads the event's samples from the waveform RAM, wrapping from start_addr to stop_addr. It streams the samples downstream with valid/ready backpressure, then pulses wvb_rddone so the overflow controller can free the space. It sits between the per-channel header FIFO / waveform RAM and the readout arbiter.

## Interface
Parameters:
- P_ADR_WIDTH, 12, waveform RAM address width
- P_DATA_WIDTH, 22, waveform RAM word width
- P_HDR_WIDTH, 80, header bundle width

Header layout is fixed: [79:32] evt_ltc, [31:20] start_addr, [19:8] stop_addr, [7:6] trig_src, [5] cnst_run, [4:0] pre_conf.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  readout enable; sampled only in IDLE
- hdr_data  in  P_HDR_WIDTH  header FIFO head (first-word-fall-through)
- hdr_empty  in  1  header FIFO empty
- hdr_rdreq  out  1  header FIFO pop, single-cycle pulse
- wvb_rd_addr  out  P_ADR_WIDTH  waveform RAM read address
- wvb_rd_en  out  1  waveform RAM read enable
- wvb_data  in  P_DATA_WIDTH  RAM read data, valid exactly 1 cycle after wvb_rd_en
- wvb_rddone  out  1  event fully consumed, single-cycle pulse
- hdr_out  out  P_HDR_WIDTH  latched header of the current event, stable while busy
- dout  out  P_DATA_WIDTH  sample data
- dout_valid  out  1  sample valid
- dout_ready  in  1  downstream accepts the sample when valid && ready
- dout_first  out  1  qualifies the first sample of the event
- dout_last  out  1  qualifies the last sample of the event
- busy  out  1  high from header pop through the wvb_rddone cycle

## Operation
- States: IDLE, LOAD, STREAM, DONE.
- IDLE: when en && !hdr_empty, pulse hdr_rdreq, latch hdr_data into hdr_out, and go to LOAD.
- LOAD (1 cycle): compute the event length as n = ((stop_addr - start_addr) mod 2^P_ADR_WIDTH) + 1, held in P_ADR_WIDTH+1 bits. The range is 1..2^P_ADR_WIDTH.
  - start_addr == stop_addr gives n = 1.
  - start_addr == stop_addr+1 gives n = 4096, the full buffer.
  - Initialize the read address to start_addr and go to STREAM.
- STREAM: issue reads at consecutive addresses, wrapping 4095 -> 0, until n reads have been issued.
  - Samples are presented on dout in address order.
  - No sample is lost or duplicated under any dout_ready pattern.
  - Use at most 2 words of internal skid storage.
  - Never issue a read whose result cannot be stored.
  - dout_first is high on sample 0; dout_last is high on sample n-1. Both are high together when n = 1.
  - After the last sample handshake, go to DONE.
- DONE (1 cycle): pulse wvb_rddone, then return to IDLE. busy drops the cycle after DONE.
- en low during an event does not abort it. The event completes; only new header pops are blocked.
- hdr_data is not sampled outside IDLE. Headers arriving mid-event wait in the FIFO.

## Timing
- Reset (async assert, synchronous-to-clk release): state IDLE.
  - hdr_rdreq, wvb_rd_en, wvb_rddone, dout_valid, dout_first, dout_last, and busy are all 0.
  - hdr_out, dout, and wvb_rd_addr are 0. Skid storage is emptied.
  - Reset mid-event drops the event with no wvb_rddone.
- Latency with dout_ready held high:
  - hdr_rdreq at cycle T.
  - First wvb_rd_en at T+2.
  - First dout_valid no later than T+3.
  - Then 1 sample per cycle.
  - wvb_rddone 1 cycle after the last handshake.
- Back-to-back events: the next hdr_rdreq is allowed the cycle after wvb_rddone. Minimum event overhead is 4 cycles.
- dout, dout_first, and dout_last hold stable while dout_valid && !dout_ready.
- dout_valid never drops without a handshake.
- wvb_rd_addr is don't-care when wvb_rd_en is 0. It holds its last value.

## Test plan
- Single event, start=0x010, stop=0x013, dout_ready=1.
  - Expect hdr_rdreq once, reads 0x010..0x013, 4 samples.
  - first on sample 0, last on sample 3, wvb_rddone 1 cycle after the last handshake.
- Wrap event, start=0xFFE, stop=0x001.
  - Expect reads 0xFFE, 0xFFF, 0x000, 0x001 and n=4.
- Single-sample event, start=stop=0x100.
  - Expect one sample with dout_first=dout_last=1.
- Full-buffer event, start=0x000, stop=0xFFF, random dout_ready at 30% duty.
  - Expect exactly 4096 samples in order matching the RAM model, with no drops or duplicates.
- Three queued headers with en toggled low during event 2.
  - Expect event 2 to complete with wvb_rddone, and no pop of header 3 until en is high again.
- rst asserted in the middle of STREAM of a 100-sample event.
  - All outputs reach their reset values with no wvb_rddone.
  - After release, the next header is read normally.
